// File: rtl/regfile_writeback_queue.sv
// Write-back FIFO in front of the register file: queues register writes, drains one per
// cycle onto a registered one-hot write bus, and exposes pending data through a bypass lookup.
module regfile_writeback_queue #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inValid,
    output logic                inReady,
    input  logic [ADDR_W-1:0]   inAddr,
    input  logic [DATA_W-1:0]   inData,
    input  logic                drainEn,
    output logic                regWrite,
    output logic [NUM_REGS-1:0] decOut,
    output logic [DATA_W-1:0]   writeData,
    input  logic [ADDR_W-1:0]   lookupAddr,
    output logic                lookupHit,
    output logic [DATA_W-1:0]   lookupData,
    output logic [ADDR_W-1:0]   count,
    output logic                full,
    output logic                empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_FULL = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [ADDR_W-1:0]   r_count;
    logic                r_reg_write;
    logic [NUM_REGS-1:0] r_dec_out;
    logic [DATA_W-1:0]   r_write_data;

    logic                w_push;
    logic                w_pop;
    logic                w_hit;
    logic [DATA_W-1:0]   w_lookup_data;

    assign full     = (r_count == CNT_FULL);
    assign empty    = (r_count == '0);
    assign inReady  = !full;
    assign count    = r_count;
    assign w_push   = inValid && inReady;
    assign w_pop    = drainEn && !empty;

    assign regWrite  = r_reg_write;
    assign decOut    = r_dec_out;
    assign writeData = r_write_data;

    // Storage is not cleared on reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_addr[r_wr_ptr] <= inAddr;
            r_data[r_wr_ptr] <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_reg_write  <= 1'b0;
            r_dec_out    <= '0;
            r_write_data <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_reg_write  <= 1'b1;
                r_dec_out    <= NUM_REGS'(1) << r_addr[r_rd_ptr];
                r_write_data <= r_data[r_rd_ptr];
            end else begin
                r_reg_write <= 1'b0;
                r_dec_out   <= '0;
            end
        end
    end

    // Walk oldest to newest so the newest matching entry wins; output stage is lowest priority.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_hit         = 1'b0;
        w_lookup_data = '0;
        idx           = '0;
        if (r_reg_write && r_dec_out[lookupAddr]) begin
            w_hit         = 1'b1;
            w_lookup_data = r_write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_rd_ptr + PTR_W'(k);
            if ((ADDR_W'(k) < r_count) && (r_addr[idx] == lookupAddr)) begin
                w_hit         = 1'b1;
                w_lookup_data = r_data[idx];
            end
        end
    end

    assign lookupHit  = w_hit;
    assign lookupData = w_lookup_data;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, single write, back-pressure,
// lookup priority, pointer wrap and mid-flight reset.
module tb_regfile_writeback_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [2:0]  inAddr;
    logic [15:0] inData;
    logic        drainEn;
    logic        regWrite;
    logic [7:0]  decOut;
    logic [15:0] writeData;
    logic [2:0]  lookupAddr;
    logic        lookupHit;
    logic [15:0] lookupData;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_writeback_queue #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inAddr(inAddr), .inData(inData), .drainEn(drainEn), .regWrite(regWrite),
        .decOut(decOut), .writeData(writeData), .lookupAddr(lookupAddr),
        .lookupHit(lookupHit), .lookupData(lookupData), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; inValid = 1'b0; inAddr = '0; inData = '0; drainEn = 1'b0; lookupAddr = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (regWrite !== 1'b0) begin n_bad++; $display("FAIL reset_regWrite got=%0b exp=0", regWrite); end
        n_cmp++; if (decOut !== 8'h00) begin n_bad++; $display("FAIL reset_decOut got=%h exp=00", decOut); end
        n_cmp++; if (writeData !== 16'h0000) begin n_bad++; $display("FAIL reset_writeData got=%h exp=0000", writeData); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL reset_inReady got=%0b exp=1", inReady); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    endtask

    task automatic test_single_write();
        drainEn = 1'b1; inValid = 1'b1; inAddr = 3'd3; inData = 16'hBEEF;
        tick();
        inValid = 1'b0;
        n_cmp++; if (regWrite !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass got=%0b exp=0", regWrite); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
        tick();
        n_cmp++; if (regWrite !== 1'b1) begin n_bad++; $display("FAIL single_regWrite got=%0b exp=1", regWrite); end
        n_cmp++; if (decOut !== 8'h08) begin n_bad++; $display("FAIL single_decOut got=%h exp=08", decOut); end
        n_cmp++; if (writeData !== 16'hBEEF) begin n_bad++; $display("FAIL single_data got=%h exp=beef", writeData); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
        tick();
        n_cmp++; if (regWrite !== 1'b0 || decOut !== 8'h00) begin n_bad++; $display("FAIL single_idle got=%0b/%h exp=0/00", regWrite, decOut); end
        n_cmp++; if (writeData !== 16'hBEEF) begin n_bad++; $display("FAIL single_hold got=%h exp=beef", writeData); end
        drainEn = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        logic [2:0]  ea [5];
        logic [15:0] ed [5];
        logic [2:0]  ec [5];
        logic [7:0]  edec;
        ea = '{3'd1, 3'd4, 3'd6, 3'd7, 3'd2};
        ed = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        ec = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        drainEn = 1'b0; inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inAddr = ea[i]; inData = ed[i];
            tick();
            if (i >= 3) begin
                n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count%0d got=%0d exp=4", i, count); end
            end
        end
        n_cmp++; if (full !== 1'b1 || inReady !== 1'b0) begin n_bad++; $display("FAIL fill_full got=%0b/%0b exp=1/0", full, inReady); end
        // 5th request is still presented; it gets in only once a slot frees up
        drainEn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) inValid = 1'b0;
            edec = 8'h01 << ea[k];
            n_cmp++; if (regWrite !== 1'b1) begin n_bad++; $display("FAIL drain%0d_regWrite got=%0b exp=1", k, regWrite); end
            n_cmp++; if (decOut !== edec) begin n_bad++; $display("FAIL drain%0d_decOut got=%h exp=%h", k, decOut, edec); end
            n_cmp++; if (writeData !== ed[k]) begin n_bad++; $display("FAIL drain%0d_data got=%h exp=%h", k, writeData, ed[k]); end
            n_cmp++; if (count !== ec[k]) begin n_bad++; $display("FAIL drain%0d_count got=%0d exp=%0d", k, count, ec[k]); end
        end
        tick();
        n_cmp++; if (regWrite !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL drain_done got=%0b/%0b exp=0/1", regWrite, empty); end
        drainEn = 1'b0;
    endtask

    task automatic test_lookup_ordering();
        drainEn = 1'b0; inValid = 1'b1; inAddr = 3'd2; inData = 16'h0001; lookupAddr = 3'd2;
        #1;
        n_cmp++; if (lookupHit !== 1'b0) begin n_bad++; $display("FAIL lk_push_invisible got=%0b exp=0", lookupHit); end
        tick();
        inData = 16'h0002;
        #1;
        n_cmp++; if (lookupData !== 16'h0001) begin n_bad++; $display("FAIL lk_inflight got=%h exp=0001", lookupData); end
        tick();
        inValid = 1'b0;
        #1;
        n_cmp++; if (lookupHit !== 1'b1 || lookupData !== 16'h0002) begin n_bad++; $display("FAIL lk_newest got=%0b/%h exp=1/0002", lookupHit, lookupData); end
        lookupAddr = 3'd5;
        #1;
        n_cmp++; if (lookupHit !== 1'b0 || lookupData !== 16'h0000) begin n_bad++; $display("FAIL lk_miss got=%0b/%h exp=0/0000", lookupHit, lookupData); end
        lookupAddr = 3'd2;
        drainEn = 1'b1;
        tick();
        n_cmp++; if (writeData !== 16'h0001) begin n_bad++; $display("FAIL ord_first got=%h exp=0001", writeData); end
        n_cmp++; if (lookupHit !== 1'b1 || lookupData !== 16'h0002) begin n_bad++; $display("FAIL lk_fifo_over_out got=%0b/%h exp=1/0002", lookupHit, lookupData); end
        tick();
        n_cmp++; if (writeData !== 16'h0002 || decOut !== 8'h04) begin n_bad++; $display("FAIL ord_second got=%h/%h exp=0002/04", writeData, decOut); end
        n_cmp++; if (lookupHit !== 1'b1 || lookupData !== 16'h0002) begin n_bad++; $display("FAIL lk_outstage got=%0b/%h exp=1/0002", lookupHit, lookupData); end
        tick();
        n_cmp++; if (lookupHit !== 1'b0) begin n_bad++; $display("FAIL lk_committed got=%0b exp=0", lookupHit); end
        drainEn = 1'b0;
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int committed = 0;
        int cyc = 0;
        logic [7:0]  edec;
        logic [15:0] edat;
        while (committed < 10 && cyc < 200) begin
            inValid = (pushed < 10);
            inAddr  = 3'(pushed % 8);
            inData  = 16'h1000 + 16'(pushed);
            drainEn = cyc[0];
            #1;
            if (inValid && inReady) pushed++;
            tick();
            cyc++;
            if (count > 3'd4) begin n_cmp++; n_bad++; $display("FAIL wrap_count got=%0d exp<=4", count); end
            if (regWrite === 1'b1) begin
                edec = 8'h01 << (committed % 8);
                edat = 16'h1000 + 16'(committed);
                n_cmp++; if (writeData !== edat || decOut !== edec) begin n_bad++; $display("FAIL wrap%0d got=%h/%h exp=%h/%h", committed, writeData, decOut, edat, edec); end
                committed++;
            end
        end
        n_cmp++; if (committed != 10) begin n_bad++; $display("FAIL wrap_total got=%0d exp=10", committed); end
        inValid = 1'b0; drainEn = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        drainEn = 1'b0; inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inAddr = 3'(i + 4); inData = 16'hC000 + 16'(i);
            tick();
        end
        inValid = 1'b0; drainEn = 1'b1;
        tick();
        n_cmp++; if (regWrite !== 1'b1 || count !== 3'd3) begin n_bad++; $display("FAIL rstmid_pre got=%0b/%0d exp=1/3", regWrite, count); end
        reset = 1'b1; inValid = 1'b1; inAddr = 3'd1; inData = 16'hDEAD;
        tick();
        reset = 1'b0; inValid = 1'b0;
        #1;
        n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_post got=%0b/%0d/%0b exp=0/0/1", regWrite, count, empty); end
        for (int a = 0; a < 8; a++) begin
            lookupAddr = 3'(a);
            #1;
            n_cmp++; if (lookupHit !== 1'b0) begin n_bad++; $display("FAIL rstmid_lookup%0d got=%0b exp=0", a, lookupHit); end
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (regWrite !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale%0d got=%0b exp=0 data=%h", c, regWrite, writeData); end
        end
        drainEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_backpressure();
        test_lookup_ordering();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
